// File: rtl/icache_line_responder.sv
// Single-line instruction buffer answering fetch line reads; misses refill the
// line word by word over a pipelined req/gnt/rvalid memory port.
module icache_line_responder #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         read_req_i,
  input  logic [ADDR_W-1:0]            addr_i,
  output logic                         read_done_o,
  output logic [LINE_WORDS*WORD_W-1:0] line_o,
  output logic                         busy_o,
  output logic                         mem_req_o,
  output logic [ADDR_W-1:0]            mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [WORD_W-1:0]            mem_rdata_i
);

  // state | meaning
  // IDLE  | waiting for a request (fresh or pending from DRAIN)
  // REQ   | issuing word requests for the refill
  // WAIT  | all words granted, collecting responses
  // DONE  | read_done_o pulse, line_o valid
  // DRAIN | flushed with responses in flight; discarding them
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int BYTES_W = WORD_W / 8;
  localparam int OFF_W   = $clog2(LINE_WORDS * BYTES_W);
  localparam int IDX_W   = $clog2(LINE_WORDS);
  localparam int CNT_W   = IDX_W + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  logic [2:0]                   state_q, state_d;
  logic [ADDR_W-1:0]            base_q, base_d;
  logic [ADDR_W-1:0]            tag_q, tag_d;
  logic [ADDR_W-1:0]            pend_addr_q, pend_addr_d;
  logic                         buf_valid_q, buf_valid_d;
  logic                         pend_q, pend_d;
  logic [CNT_W-1:0]             issue_q, issue_d;
  logic [CNT_W-1:0]             resp_q, resp_d;
  logic [LINE_WORDS*WORD_W-1:0] line_q, line_d;

  logic              fill, gnt_fire, rsp_ok, last_rsp, start;
  logic [CNT_W-1:0]  issue_inc, resp_inc;
  logic [ADDR_W-1:0] req_base;

  assign fill      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign gnt_fire  = (state_q == S_REQ) && mem_gnt_i;
  assign issue_inc = issue_q + CNT_W'(gnt_fire);
  // Responses with nothing outstanding are protocol violations and dropped.
  assign rsp_ok    = mem_rvalid_i && (issue_inc != resp_q) && (fill || state_q == S_DRAIN);
  assign resp_inc  = resp_q + CNT_W'(rsp_ok);
  assign last_rsp  = rsp_ok && fill && (resp_q == CNT_W'(LINE_WORDS - 1));
  assign start     = read_req_i || pend_q;
  assign req_base  = (pend_q ? pend_addr_q : addr_i) & LINE_MASK;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    tag_d       = tag_q;
    pend_addr_d = pend_addr_q;
    buf_valid_d = buf_valid_q;
    pend_d      = pend_q;
    issue_d     = issue_q;
    resp_d      = resp_q;
    line_d      = line_q;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          pend_d = 1'b0;
        end else if (start) begin
          pend_d = 1'b0;
          if (buf_valid_q && (tag_q == req_base)) begin
            state_d = S_DONE;
          end else begin
            base_d      = req_base;
            issue_d     = '0;
            resp_d      = '0;
            buf_valid_d = 1'b0;
            state_d     = S_REQ;
          end
        end
      end
      S_REQ, S_WAIT: begin
        issue_d = issue_inc;
        resp_d  = resp_inc;
        if (rsp_ok) line_d[int'(resp_q[IDX_W-1:0]) * WORD_W +: WORD_W] = mem_rdata_i;
        if (flush_i) begin
          state_d = (issue_inc != resp_inc) ? S_DRAIN : S_IDLE;
        end else if (last_rsp) begin
          tag_d       = base_q;
          buf_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if ((state_q == S_REQ) && (issue_inc == CNT_W'(LINE_WORDS))) begin
          state_d = S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_DRAIN: begin
        resp_d = resp_inc;
        if (flush_i) begin
          pend_d = 1'b0;
        end else if (read_req_i) begin
          pend_d      = 1'b1;
          pend_addr_d = addr_i;
        end
        if (issue_q == resp_inc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      tag_q       <= '0;
      pend_addr_q <= '0;
      buf_valid_q <= 1'b0;
      pend_q      <= 1'b0;
      issue_q     <= '0;
      resp_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      tag_q       <= tag_d;
      pend_addr_q <= pend_addr_d;
      buf_valid_q <= buf_valid_d;
      pend_q      <= pend_d;
      issue_q     <= issue_d;
      resp_q      <= resp_d;
      line_q      <= line_d;
    end
  end

  assign read_done_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_addr_o  = mem_req_o ? (base_q + ADDR_W'(issue_q) * ADDR_W'(BYTES_W)) : '0;
  assign line_o      = line_q;

endmodule

// File: tb/tb_icache_line_responder.sv
// Directed bench for icache_line_responder with an in-order memory responder
// whose grants and response delivery are switched by the stimulus.
module tb_icache_line_responder;

  logic         clk_i = 1'b0;
  logic         rst_i, flush_i, read_req_i;
  logic [31:0]  addr_i;
  logic         read_done_o, busy_o, mem_req_o;
  logic [127:0] line_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i, mem_rvalid_i;
  logic [31:0]  mem_rdata_i;

  logic         gnt_en, rsp_en;
  logic [31:0]  q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           lat;

  localparam logic [127:0] LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] LINE_E = 128'h000000E3_000000E2_000000E1_000000E0;

  icache_line_responder dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .read_req_i(read_req_i),
    .addr_i(addr_i), .read_done_o(read_done_o), .line_o(line_o), .busy_o(busy_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;
  assign mem_gnt_i = mem_req_o & gnt_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {24'h0, a[9:2] + 8'h60};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; memory sees the grant before the edge and answers one cycle later.
  task automatic tick();
    if (mem_rvalid_i) void'(q.pop_front());
    if (mem_req_o && gnt_en) q.push_back(mem_addr_o);
    @(posedge clk_i); #1;
    if (rsp_en && q.size() > 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mem_word(q[0]);
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end
  endtask

  task automatic req(input logic [31:0] a);
    read_req_i = 1'b1;
    addr_i     = a;
    tick();
    read_req_i = 1'b0;
  endtask

  task automatic wait_done(input int first, input int limit, output int l);
    l = first;
    while (!read_done_o && l < limit) begin
      tick();
      l++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; read_req_i = 1'b0; addr_i = '0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; gnt_en = 1'b1; rsp_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_done", read_done_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_line", line_o, 0);
    @(negedge clk_i) rst_i = 1'b0;
    tick();

    // cold miss
    req(32'h104);
    for (int i = 0; i < 4; i++) begin
      chk("miss_req", mem_req_o, 1);
      chk("miss_addr", mem_addr_o, 32'h100 + 32'(4 * i));
      tick();
    end
    wait_done(5, 20, lat);
    chk("miss_done", read_done_o, 1);
    chk("miss_lat", lat, 6);
    chk("miss_line", line_o, LINE_A);
    tick();

    // hit
    req(32'h10C);
    chk("hit_done", read_done_o, 1);
    chk("hit_req", mem_req_o, 0);
    chk("hit_line", line_o, LINE_A);
    tick();
    chk("hit_idle", busy_o, 0);

    // flush with two responses in flight, request captured during drain
    rsp_en = 1'b0;
    req(32'h300);
    tick();
    tick();
    gnt_en = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("drain_busy", busy_o, 1);
    chk("drain_req", mem_req_o, 0);
    rsp_en = 1'b1; read_req_i = 1'b1; addr_i = 32'h200;
    tick();
    read_req_i = 1'b0;
    chk("drain_rv", mem_rvalid_i, 1);
    tick();
    tick();
    chk("drain_exit", busy_o, 0);
    chk("drain_line", line_o, LINE_A);
    gnt_en = 1'b1;
    tick();
    chk("pend_req", mem_req_o, 1);
    chk("pend_addr", mem_addr_o, 32'h200);
    wait_done(0, 20, lat);
    chk("pend_done", read_done_o, 1);
    chk("pend_line", line_o, LINE_E);
    tick();

    // follow-up to 0x100 misses, with a 3-cycle grant stall on word 1
    req(32'h100);
    chk("stall_miss", mem_req_o, 1);
    chk("stall_a0", mem_addr_o, 32'h100);
    tick();
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_hold", mem_addr_o, 32'h104);
      tick();
    end
    gnt_en = 1'b1;
    wait_done(5, 30, lat);
    chk("stall_done", read_done_o, 1);
    chk("stall_lat", lat, 9);
    chk("stall_line", line_o, LINE_A);
    tick();

    // flush in IDLE drops the same-cycle request
    read_req_i = 1'b1; addr_i = 32'h500; flush_i = 1'b1;
    tick();
    read_req_i = 1'b0; flush_i = 1'b0;
    chk("fidle_busy", busy_o, 0);
    chk("fidle_req", mem_req_o, 0);
    tick();
    chk("fidle_busy2", busy_o, 0);

    // reset during WAIT
    rsp_en = 1'b0;
    req(32'h600);
    repeat (4) tick();
    chk("wait_busy", busy_o, 1);
    chk("wait_req", mem_req_o, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("mrst_done", read_done_o, 0);
    chk("mrst_req", mem_req_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_addr", mem_addr_o, 0);
    chk("mrst_line", line_o, 0);
    q.delete();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; rsp_en = 1'b1;
    @(negedge clk_i) rst_i = 1'b0;
    tick();
    req(32'h104);
    chk("post_miss", mem_req_o, 1);
    chk("post_addr", mem_addr_o, 32'h100);
    wait_done(1, 20, lat);
    chk("post_lat", lat, 6);
    chk("post_line", line_o, LINE_A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/icache_line_responder.md
# icache_line_responder

Responder side of the fetch read handshake: accepts a one-cycle `read_req_i` plus fetch address from the fetch controller and answers with a `read_done_o` pulse carrying the full instruction line. The block holds a single-line buffer. A request to the buffered line is a hit and needs no memory traffic. A miss refills the buffer word by word over a pipelined req/gnt/rvalid memory port. The block sits between the fetch controller and instruction memory, and honours the same `flush_i` used by the fetch stage.

## Interface
- `ADDR_W`, 32, byte-address width.
- `WORD_W`, 32, memory word width; must be a multiple of 8.
- `LINE_WORDS`, 4, words per line; power of two, ≥2.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `flush_i`  in  1  abort current activity (pipeline flush).
- `read_req_i`  in  1  line read request (one-cycle pulse).
- `addr_i`  in  ADDR_W  fetch byte address; line-offset bits are ignored.
- `read_done_o`  out  1  one-cycle pulse; `line_o` is valid in this cycle.
- `line_o`  out  LINE_WORDS*WORD_W  line data; word 0 is in the LSBs.
- `busy_o`  out  1  high in every state except IDLE.
- `mem_req_o`  out  1  memory word request.
- `mem_addr_o`  out  ADDR_W  word byte address.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  in-order read response.
- `mem_rdata_i`  in  WORD_W  response data.

## Operation
- Line base = `addr_i` with its low log2(LINE_WORDS*WORD_W/8) bits cleared.
- Internal registers:
  - buffer tag and `buf_valid`;
  - line buffer;
  - issue counter and response counter, each clog2(LINE_WORDS)+1 bits;
  - pending-request bit plus pending address.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - On `read_req_i`, or on a pending request from DRAIN: if `buf_valid` and the tag equals the line base, go to DONE (hit).
  - Otherwise latch the base, clear both counters, clear `buf_valid`, and go to REQ.
- REQ:
  - `mem_req_o`=1 and `mem_addr_o` = base + issue_cnt*(WORD_W/8).
  - Issue count increments on `mem_gnt_i`.
  - After the LINE_WORDS-th grant, go to WAIT.
- REQ and WAIT, responses:
  - Each `mem_rvalid_i` writes `mem_rdata_i` into buffer word resp_cnt, then resp_cnt increments.
  - When the last response arrives, set tag and `buf_valid` and go to DONE. This can happen while still in REQ if the last grant and last response coincide.
- DONE:
  - `read_done_o`=1 for exactly one cycle, then return to IDLE.
  - `line_o` stays stable from DONE until the first write of the next miss.
- Outstanding responses = issue_cnt − resp_cnt, counting a grant in the current cycle.
- `flush_i` (overrides every other transition):
  - From REQ or WAIT: if responses are outstanding go to DRAIN, else go to IDLE. `buf_valid` stays 0.
  - From DONE: `read_done_o` is still 1 in that cycle; go to IDLE with `buf_valid` kept.
  - From IDLE: the same-cycle `read_req_i` is dropped.
  - From DRAIN: any pending request is cleared.
- DRAIN:
  - `mem_req_o`=0; incoming responses are discarded.
  - Once outstanding reaches 0, go to IDLE.
  - A `read_req_i` arriving in DRAIN is captured as pending (address latched) and served on entry to IDLE.
- `read_req_i` in REQ, WAIT or DONE is ignored; the requester must not issue one then.
- `mem_rvalid_i` with nothing outstanding is a protocol violation and is ignored.

## Timing
- Reset values:
  - state IDLE;
  - `read_done_o`=0, `mem_req_o`=0, `busy_o`=0;
  - `mem_addr_o`=0, `line_o`=0;
  - `buf_valid`=0, pending=0, both counters 0.
- `read_done_o`, `mem_req_o`, `mem_addr_o` and `busy_o` are decoded from registered state and counters only. There is no combinational path from any input to any output.
- Hit latency: `read_req_i` in cycle t gives `read_done_o` in t+1.
- Miss latency, with zero-wait grant and 1-cycle response, LINE_WORDS=4:
  - request at t;
  - `mem_req_o` high t+1..t+4;
  - responses t+2..t+5;
  - `read_done_o` at t+6.
- Grant stalls extend REQ cycle by cycle, and `mem_addr_o` holds until granted. Response gaps extend WAIT.
- Reset asserted mid-miss returns the block to IDLE immediately. In-flight memory responses after reset are not the block's responsibility; the memory is reset with it.

## Test plan
- Cold miss, LINE_WORDS=4, `addr_i`=0x104, immediate grants, rdata 0xA0..0xA3:
  - `mem_addr_o` = 0x100, 0x104, 0x108, 0x10C;
  - `read_done_o` at t+6;
  - `line_o`=0x000000A3_000000A2_000000A1_000000A0.
- Hit: repeat with `addr_i`=0x10C → `read_done_o` at t+1, no `mem_req_o`, same `line_o`.
- Grant stall:
  - `mem_gnt_i` low for 3 cycles on word 1 → `mem_addr_o` holds 0x104 for those cycles;
  - `read_done_o` is 3 cycles later than the no-stall case; data is correct.
- Flush with 2 outstanding responses:
  - block enters DRAIN and discards both responses;
  - `read_req_i` for 0x200 during DRAIN is served afterwards as a miss to 0x200;
  - a follow-up request to 0x100 misses.
- Flush in the same cycle as `read_req_i` in IDLE → request dropped, `busy_o` stays 0.
- Reset asserted during WAIT → all outputs return to reset values; the next request to 0x104 is a miss.
